// File: rtl/logic_unit_pkg.sv
// Shared opcodes and FSM state encodings for the
// round-robin shared logic unit.
package logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational WIDTH-bit bitwise unit: AND, OR, XOR, NOR.
// Results are exactly WIDTH bits; no carries.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_AND: result = x & y;
            OP_OR:  result = x | y;
            OP_XOR: result = x ^ y;
            OP_NOR: result = ~(x | y);
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end serialising access to
// one logic unit; one operation in flight at a time.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero
);

    state_t           state;
    state_t           state_nx;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             cap_id;
    logic [1:0]       cap_op;
    logic [WIDTH-1:0] cap_x;
    logic [WIDTH-1:0] cap_y;
    logic [WIDTH-1:0] result;

    // Grant goes to the sole valid requester, or on contention
    // to whichever one did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state == ST_IDLE) begin
            unique case (1'b1)
                req0_valid && req1_valid: begin
                    grant0 = last_grant;
                    grant1 = !last_grant;
                end
                req0_valid && !req1_valid: grant0 = 1'b1;
                !req0_valid && req1_valid: grant1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign rsp_valid  = (state == ST_RESP);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept) state_nx = ST_EXEC;
            ST_EXEC: state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    logic_unit #(
        .WIDTH(WIDTH)
    ) u_logic (
        .op    (cap_op),
        .x     (cap_x),
        .y     (cap_y),
        .result(result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            cap_id     <= 1'b0;
            cap_op     <= '0;
            cap_x      <= '0;
            cap_y      <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                last_grant <= grant1;
                cap_id     <= grant1;
                cap_op     <= grant1 ? req1_op : req0_op;
                cap_x      <= grant1 ? req1_x : req0_x;
                cap_y      <= grant1 ? req1_y : req0_y;
            end
            if (state == ST_EXEC) begin
                rsp_id   <= cap_id;
                rsp_data <= result;
                rsp_zero <= (result == '0);
            end
        end
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares a single bitwise logic unit (AND/OR/XOR/NOR on WIDTH-bit operands) between two requesters, using round-robin arbitration. Each request and each result uses a valid/ready handshake. Only one operation is in flight at a time. The block sits between the ALU front-end ports and the logic datapath, and serialises access to the logic datapath.

## Interface
Parameters:
- WIDTH, 4, operand/result width in bits

Ports:
- clk  in  1  rising-edge clock, single domain
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOR
- req0_x, req0_y  in  WIDTH  operands
- req1_valid, req1_ready, req1_op, req1_x, req1_y  same as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_data  out  WIDTH  result
- rsp_zero  out  1  rsp_data == 0

## Operation
- FSM states:
  - IDLE: arbitrate; on accept, go to EXEC.
  - EXEC: compute and register the result; go to RESP unconditionally.
  - RESP: rsp_valid=1; on rsp_ready, go to IDLE.
- Acceptance: a handshake occurs when the granted reqN_valid and reqN_ready are both 1 at a clk edge. Op, x and y are captured into internal registers at that edge.
- reqN_ready: high only in IDLE, and only for the granted requester. It is combinational from state, valids and last_grant. It is forced to 0 while rst_n=0. It never depends on reqN_ready.
- Arbitration in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester ≠ last_grant is granted.
  - last_grant updates on each accept.
- Result: the computed value and rsp_zero are registered at the EXEC→RESP edge. rsp_data, rsp_id and rsp_zero hold stable while rsp_valid=1 and rsp_ready=0.
- Requesters must hold valid and operands until ready. The block does not check this.
- Reset values: state=IDLE, last_grant=1 (requester 0 wins first contention), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, captured operands/op=0.
- Reset mid-operation: any edge with rst_n=0 aborts EXEC or RESP. No response is emitted for the aborted operation.

## Timing
- Accept at edge N (IDLE→EXEC); result registered at edge N+1; rsp_valid visible from cycle N+1 to N+2 boundary onward.
- Zero-wait consumer (rsp_ready=1): rsp_valid high exactly one cycle. The next accept can occur at edge N+3. Maximum throughput is 1 op per 3 cycles.
- In RESP, readies are 0 even if rsp_ready=1. The new grant is evaluated in the following IDLE cycle.
- A reqN_valid that arrives during EXEC or RESP waits. There is no queueing beyond the requester's own hold.
- NOR is ~(x|y) truncated to WIDTH. No carries; all results are exactly WIDTH bits.

## Structure
- Shared package logic_unit_pkg:
  - opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11
  - state encodings ST_IDLE, ST_EXEC, ST_RESP (2 bits)
- Sub-module logic_unit (purely combinational, WIDTH-parameterised: op, x, y → result) is instantiated once on the captured operands.
- The arbiter, FSM and response registers live in logic_unit_arbiter.

## Test plan
- Reset/single op:
  - Stimulus: hold rst_n=0 for 2 cycles, then release; req0 OR x=4'b1010 y=4'b0101, rsp_ready=1.
  - Required: req0_ready=1 in the first IDLE cycle; rsp_valid for exactly one cycle, 2 cycles after accept; rsp_data=4'b1111, rsp_id=0, rsp_zero=0.
- Contention:
  - Stimulus: both requesters continuously valid (req0 AND 4'hC,4'hA; req1 XOR 4'hF,4'hF).
  - Required: grants alternate 0,1,0,1; responses 4'h8/id0, 4'h0/id1 with rsp_zero=1; accepts 3 cycles apart.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid rises; req1 valid meanwhile.
  - Required: rsp_valid, rsp_data and rsp_id stable for all 5 cycles; req1_ready=0 throughout; req1 accepted in the IDLE cycle after the response handshake.
- NOR/width:
  - Stimulus: req1 NOR x=4'h3 y=4'h4.
  - Required: rsp_data=4'h8, no upper-bit leakage; also check with WIDTH=8 (x=8'h0F, y=8'hF0 → 8'h00, rsp_zero=1).
- Reset mid-op:
  - Stimulus: assert rst_n=0 in EXEC, and separately in RESP.
  - Required: rsp_valid=0 at the next edge, no stale response afterward; first post-reset contention granted to req0.
- Idle stability:
  - Stimulus: no valids for 20 cycles.
  - Required: both readies 0, rsp_valid=0, state remains IDLE.
